// File: rtl/pc_seq_ctrl_if.sv
// Fetch/execute handshake bundle between the next-PC controller (master)
// and the instruction memory plus datapath (slave).
//
// Handshake: imem_req is raised in S_FETCH and held until imem_ack; a cycle
// with imem_req && imem_ack is the single transfer cycle, and ir_we pulses in
// exactly that cycle. exec_done is a one-cycle completion strobe, and npc_op,
// br_taken, imm16, instr_index, rs_data and halt_req are sampled only with it.
interface pc_seq_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic        ir_we;
  logic        exec_done;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_data;
  logic        halt_req;

  modport master (
    output imem_req,
    output ir_we,
    input  imem_ack,
    input  exec_done,
    input  npc_op,
    input  br_taken,
    input  imm16,
    input  instr_index,
    input  rs_data,
    input  halt_req
  );

  modport slave (
    input  imem_req,
    input  ir_we,
    output imem_ack,
    output exec_done,
    output npc_op,
    output br_taken,
    output imm16,
    output instr_index,
    output rs_data,
    output halt_req
  );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch / next-PC controller for a word-addressed PC register.
// NPC equals PC except on the exec_done cycle, where one of four sources wins.
module pc_seq_ctrl #(
  parameter int RETIRE_W  = 32,
  parameter int BOOT_HOLD = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [29:0]         PC,
  output logic [29:0]         NPC,
  pc_seq_ctrl_if.master       bus,
  output logic                halted,
  output logic                addr_err,
  output logic [RETIRE_W-1:0] retired,
  output logic [1:0]          state_dbg
);

  localparam int BW = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_HOLD - 1);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [BW-1:0] boot_cnt;
  logic [BW-1:0] boot_cnt_n;
  logic          retire_en;
  logic          aerr_set;

  logic [29:0] pc1;
  logic [29:0] br_off;
  logic [29:0] br_target;
  logic [29:0] jmp_target;
  logic        jr_misaligned;

  assign pc1           = PC + 30'd1;
  assign br_off        = {{14{bus.imm16[15]}}, bus.imm16};
  assign br_target     = pc1 + br_off;
  assign jmp_target    = {pc1[29:26], bus.instr_index};
  assign jr_misaligned = (bus.rs_data[1:0] != 2'b00);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_BOOT;
      boot_cnt <= '0;
      retired  <= '0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_n;
      boot_cnt <= boot_cnt_n;
      if (retire_en) retired <= retired + RETIRE_W'(1);
      if (aerr_set)  addr_err <= 1'b1;
    end
  end

  always_comb begin
    state_n      = state;
    boot_cnt_n   = boot_cnt;
    NPC          = PC;
    bus.imem_req = 1'b0;
    bus.ir_we    = 1'b0;
    retire_en    = 1'b0;
    aerr_set     = 1'b0;
    unique case (state)
      S_BOOT: begin
        if (boot_cnt == BOOT_LAST) state_n = S_FETCH;
        else                       boot_cnt_n = boot_cnt + BW'(1);
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.ir_we = 1'b1;
          state_n   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          // A misaligned jr leaves PC untouched and does not retire.
          if (bus.npc_op == 2'b11 && jr_misaligned) begin
            aerr_set = 1'b1;
            state_n  = S_HALT;
          end else begin
            unique case (bus.npc_op)
              2'b00: NPC = pc1;
              2'b01: NPC = bus.br_taken ? br_target : pc1;
              2'b10: NPC = jmp_target;
              2'b11: NPC = bus.rs_data[31:2];
            endcase
            retire_en = 1'b1;
            state_n   = bus.halt_req ? S_HALT : S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_BOOT;
      end
    endcase
  end

  assign halted    = (state == S_HALT);
  assign state_dbg = state;

  ir_we_only_in_fetch: assert property (@(posedge Clk) disable iff (Reset)
    bus.ir_we |-> (state == S_FETCH && bus.imem_req));
  npc_only_on_done: assert property (@(posedge Clk) disable iff (Reset)
    (NPC != PC) |-> (state == S_EXEC && bus.exec_done));
  halt_is_terminal: assert property (@(posedge Clk) disable iff (Reset)
    (state == S_HALT) |=> (state == S_HALT));

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: expected NPC values are queued when
// exec_done is driven and popped when the DUT moves NPC away from PC.
module tb_pc_seq_ctrl;
  logic        Clk;
  logic        Reset;
  logic [29:0] pc;
  logic [29:0] npc;
  logic        halted;
  logic        addr_err;
  logic [31:0] retired;
  logic [1:0]  state_dbg;

  pc_seq_ctrl_if bus();

  pc_seq_ctrl #(.RETIRE_W(32), .BOOT_HOLD(2)) dut (
    .Clk(Clk), .Reset(Reset), .PC(pc), .NPC(npc), .bus(bus),
    .halted(halted), .addr_err(addr_err), .retired(retired), .state_dbg(state_dbg)
  );

  int          checks;
  int          failures;
  int          ir_we_cnt;
  logic        started;
  logic [29:0] exp_q[$];
  logic [31:0] exp_retired;
  logic        exp_aerr;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  // Independent next-PC model using 32-bit signed arithmetic.
  function automatic logic [29:0] model_npc(input logic [29:0] p, input logic [1:0] op,
                                            input logic br, input logic [15:0] imm,
                                            input logic [25:0] idx, input logic [31:0] rs);
    logic signed [31:0] off;
    logic [31:0] t;
    logic [29:0] r;
    off = $signed(imm);
    r = p;
    case (op)
      2'd0: begin t = {2'b00, p} + 32'd1; r = t[29:0]; end
      2'd1: begin
        t = {2'b00, p} + 32'd1;
        if (br) t = t + off;
        r = t[29:0];
      end
      2'd2: begin
        t = {2'b00, p} + 32'd1;
        r = (t[29:0] & 30'h3C00_0000) | {4'b0000, idx};
      end
      default: begin
        t = rs >> 2;
        r = (rs[1:0] != 2'b00) ? p : t[29:0];
      end
    endcase
    return r;
  endfunction

  always @(negedge Clk) begin
    if (bus.ir_we === 1'b1) ir_we_cnt++;
    if (started && npc !== pc) begin
      if (exp_q.size() == 0) check("npc_spurious", {2'b00, npc}, {2'b00, pc});
      else check("npc", {2'b00, npc}, {2'b00, exp_q.pop_front()});
    end
  end

  task automatic clear_inputs();
    bus.imem_ack    = 1'b0;
    bus.exec_done   = 1'b0;
    bus.npc_op      = 2'd0;
    bus.br_taken    = 1'b0;
    bus.imm16       = 16'd0;
    bus.instr_index = 26'd0;
    bus.rs_data     = 32'd0;
    bus.halt_req    = 1'b0;
  endtask

  // Hold reset n edges, release, check boot hold; returns with DUT in S_FETCH.
  task automatic do_reset(input int n);
    Reset = 1'b1;
    clear_inputs();
    for (int i = 0; i < n; i++) begin
      tick();
      started = 1'b1;
    end
    Reset = 1'b0;
    exp_retired = 32'd0;
    exp_aerr = 1'b0;
    exp_q.delete();
    @(negedge Clk);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    tick();
    @(negedge Clk);
    check("boot_req1", {31'd0, bus.imem_req}, 32'd0);
    tick();
    @(negedge Clk);
    check("boot_req2", {31'd0, bus.imem_req}, 32'd1);
    tick();
  endtask

  task automatic run_instr(input logic [29:0] pc_v, input int ack_wait, input int exec_wait,
                           input logic [1:0] op, input logic br, input logic [15:0] imm,
                           input logic [25:0] idx, input logic [31:0] rs, input logic hreq);
    int req_cycles;
    int we0;
    logic [29:0] e;
    logic bad;
    req_cycles = 0;
    we0 = ir_we_cnt;
    pc = pc_v;
    clear_inputs();
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge Clk);
      if (bus.imem_req) req_cycles++;
      check("fetch_wait_we", {31'd0, bus.ir_we}, 32'd0);
      tick();
    end
    bus.imem_ack = 1'b1;
    @(negedge Clk);
    if (bus.imem_req) req_cycles++;
    check("fetch_ack_we", {31'd0, bus.ir_we}, 32'd1);
    tick();
    bus.imem_ack = 1'b0;
    check("req_cycles", req_cycles, ack_wait + 1);
    for (int i = 0; i < exec_wait; i++) begin
      bus.halt_req = 1'($urandom_range(0, 1));
      @(negedge Clk);
      check("exec_state", {30'd0, state_dbg}, 32'd2);
      check("exec_req", {31'd0, bus.imem_req}, 32'd0);
      tick();
    end
    e = model_npc(pc_v, op, br, imm, idx, rs);
    bad = (op == 2'd3) && (rs[1:0] != 2'b00);
    bus.exec_done   = 1'b1;
    bus.npc_op      = op;
    bus.br_taken    = br;
    bus.imm16       = imm;
    bus.instr_index = idx;
    bus.rs_data     = rs;
    bus.halt_req    = hreq;
    if (e != pc_v) exp_q.push_back(e);
    @(negedge Clk);
    if (e == pc_v) check("npc_hold", {2'b00, npc}, {2'b00, pc});
    tick();
    clear_inputs();
    if (!bad) exp_retired = exp_retired + 32'd1;
    if (bad) exp_aerr = 1'b1;
    check("npc_seen", exp_q.size(), 0);
    check("ir_we_pulses", ir_we_cnt - we0, 1);
    @(negedge Clk);
    check("retired", retired, exp_retired);
    check("halted", {31'd0, halted}, {31'd0, hreq | bad});
    check("addr_err", {31'd0, addr_err}, {31'd0, exp_aerr});
    tick();
  endtask

  initial begin
    int req_cnt;
    logic [1:0] op;
    checks = 0;
    failures = 0;
    ir_we_cnt = 0;
    started = 1'b0;
    pc = 30'd0;
    exp_retired = 32'd0;
    exp_aerr = 1'b0;

    do_reset(3);
    run_instr(30'h10, 3, 1, 2'd0, 1'b0, 16'h0000, 26'd0, 32'd0, 1'b0);
    run_instr(30'h20, 0, 0, 2'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0, 1'b0);
    run_instr(30'h20, 1, 2, 2'd1, 1'b0, 16'hFFFC, 26'd0, 32'd0, 1'b0);
    run_instr(30'h3FFF_FFFF, 0, 0, 2'd2, 1'b0, 16'h0000, 26'h000_0123, 32'd0, 1'b0);
    run_instr(30'h40, 2, 1, 2'd3, 1'b0, 16'h0000, 26'd0, 32'h0040_0000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      op = 2'($urandom_range(0, 3));
      run_instr(30'($urandom()), $urandom_range(0, 3), $urandom_range(0, 2), op,
                1'($urandom_range(0, 1)), 16'($urandom()), 26'($urandom()),
                $urandom() & 32'hFFFF_FFFC, 1'b0);
    end
    run_instr(30'h50, 0, 0, 2'd3, 1'b0, 16'h0000, 26'd0, 32'h0040_0002, 1'b0);

    do_reset(3);
    run_instr(30'h60, 1, 0, 2'd0, 1'b0, 16'h0000, 26'd0, 32'd0, 1'b1);
    req_cnt = 0;
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (bus.imem_req) req_cnt++;
      tick();
    end
    bus.imem_ack = 1'b0;
    check("halt_no_req", req_cnt, 0);
    check("halt_sticky", {31'd0, halted}, 32'd1);

    do_reset(3);
    Reset = 1'b1;
    bus.imem_ack = 1'b1;
    tick();
    @(negedge Clk);
    check("rst_fetch_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_fetch_we", {31'd0, bus.ir_we}, 32'd0);
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("post_rst_we", {31'd0, bus.ir_we}, 32'd0);
    check("post_rst_retired", retired, 32'd0);
    tick();
    bus.imem_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
